// File: rtl/imem_loader.sv
// Boot-time instruction loader: parses a framed host byte stream (sync, count, data, XOR checksum)
// into little-endian 32-bit words, writes instruction memory, and releases the core only on a verified image.
module imem_loader #(
  parameter int AW      = 5,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  input  logic [7:0]    in_data,
  output logic          in_ready,
  input  logic          restart,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          core_hold,
  output logic          done,
  output logic          error,
  output logic [1:0]    err_code,
  output logic [AW:0]   words_loaded
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_COUNT = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_CHECK = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_ERR   = 3'd5;

  localparam logic [7:0]  SYNC    = 8'hA5;
  localparam int          WLW     = AW + 1;
  localparam int          CAP     = 1 << AW;
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  localparam logic [AW:0] WL_ONE  = WLW'(1);

  logic [2:0]  state;
  logic [15:0] idle_cnt;
  logic [1:0]  bidx;
  logic [AW:0] nwords;
  logic [23:0] wbuf;
  logic [7:0]  csum;

  logic in_frame;
  logic accept;
  logic bad_count;
  logic word_end;
  logic last_word;
  logic timed_out;

  assign in_frame  = (state == S_COUNT) || (state == S_DATA) || (state == S_CHECK);
  assign in_ready  = (state == S_IDLE) || in_frame;
  assign accept    = in_valid & in_ready;
  assign bad_count = (in_data == 8'd0) || (32'(in_data) > 32'(CAP));
  assign word_end  = (bidx == 2'd3);
  assign last_word = ((words_loaded + WL_ONE) == nwords);
  // An accepted byte on the expiring edge suppresses the timeout.
  assign timed_out = in_frame & ~accept & (idle_cnt == TO_LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= S_IDLE;
      idle_cnt     <= 16'd0;
      bidx         <= 2'd0;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= 32'd0;
      core_hold    <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'd0;
      words_loaded <= '0;
    end else begin
      imem_we <= 1'b0;
      if (!in_frame || accept) idle_cnt <= 16'd0;
      else                     idle_cnt <= idle_cnt + 16'd1;

      if (timed_out) begin
        state    <= S_ERR;
        error    <= 1'b1;
        err_code <= 2'd3;
      end else begin
        case (state)
          S_IDLE: if (accept && in_data == SYNC) state <= S_COUNT;
          S_COUNT: if (accept) begin
            if (bad_count) begin
              state    <= S_ERR;
              error    <= 1'b1;
              err_code <= 2'd1;
            end else begin
              state <= S_DATA;
              bidx  <= 2'd0;
            end
          end
          S_DATA: if (accept) begin
            bidx <= bidx + 2'd1;
            if (word_end) begin
              imem_we      <= 1'b1;
              imem_addr    <= words_loaded[AW-1:0];
              imem_wdata   <= {in_data, wbuf};
              words_loaded <= words_loaded + WL_ONE;
              if (last_word) state <= S_CHECK;
            end
          end
          S_CHECK: if (accept) begin
            if (in_data == csum) begin
              state     <= S_DONE;
              done      <= 1'b1;
              core_hold <= 1'b0;
            end else begin
              state    <= S_ERR;
              error    <= 1'b1;
              err_code <= 2'd2;
            end
          end
          S_DONE, S_ERR: if (restart) begin
            state        <= S_IDLE;
            done         <= 1'b0;
            error        <= 1'b0;
            err_code     <= 2'd0;
            words_loaded <= '0;
            core_hold    <= 1'b1;
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  // Datapath: count latch, running checksum and little-endian word assembly (no reset needed).
  always_ff @(posedge clk) begin
    if (accept && state == S_COUNT) begin
      nwords <= WLW'(in_data);
      csum   <= in_data;
    end else if (accept && state == S_DATA) begin
      csum <= csum ^ in_data;
      wbuf <= {in_data, wbuf[23:8]};
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: directed frames with literal expectations plus randomized frames
// compared every cycle against a frame-level reference model.
module tb_imem_loader;

  localparam int AW      = 5;
  localparam int TIMEOUT = 255;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          in_valid = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          restart = 1'b0;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_hold;
  logic          done;
  logic          error;
  logic [1:0]    err_code;
  logic [AW:0]   words_loaded;

  imem_loader #(.AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .restart(restart), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_hold(core_hold), .done(done), .error(error), .err_code(err_code),
    .words_loaded(words_loaded)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic [31:0] mem [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase 0 hunt, 1 count, 2 data, 3 check, 4 done, 5 err.
  int          m_phase = 0;
  int          m_n = 0;
  int          m_nb = 0;
  int          m_idle = 0;
  logic [7:0]  m_csum = 8'h00;
  logic [7:0]  m_bytes [128];
  logic        e_we = 1'b0;
  int          e_addr = 0;
  logic [31:0] e_wdata = 32'd0;
  logic        e_done = 1'b0;
  logic        e_error = 1'b0;
  int          e_code = 0;
  int          e_wl = 0;
  logic        e_hold = 1'b1;

  task automatic model_reset();
    m_phase = 0; m_n = 0; m_nb = 0; m_idle = 0;
    e_we = 1'b0; e_addr = 0; e_wdata = 32'd0; e_done = 1'b0; e_error = 1'b0;
    e_code = 0; e_wl = 0; e_hold = 1'b1;
  endtask

  task automatic model_fail(input int code);
    m_phase = 5; e_error = 1'b1; e_code = code;
  endtask

  task automatic model_step(input logic v, input logic [7:0] d, input logic r);
    bit acc;
    int k;
    int dv;
    if (!reset) begin
      model_reset();
      return;
    end
    dv = int'(d);
    e_we = 1'b0;
    acc = v && (m_phase < 4);
    if (m_phase >= 1 && m_phase <= 3 && !acc) begin
      m_idle++;
      if (m_idle == TIMEOUT) begin
        model_fail(3);
        return;
      end
    end else begin
      m_idle = 0;
    end
    case (m_phase)
      0: if (acc && d == 8'hA5) m_phase = 1;
      1: if (acc) begin
        if (dv == 0 || dv > (1 << AW)) model_fail(1);
        else begin
          m_n = dv; m_csum = d; m_nb = 0; m_phase = 2;
        end
      end
      2: if (acc) begin
        m_bytes[m_nb] = d;
        m_nb++;
        m_csum ^= d;
        if (m_nb % 4 == 0) begin
          k = m_nb / 4 - 1;
          e_we = 1'b1;
          e_addr = k;
          e_wdata = {m_bytes[4*k+3], m_bytes[4*k+2], m_bytes[4*k+1], m_bytes[4*k]};
          e_wl = k + 1;
          if (k + 1 == m_n) m_phase = 3;
        end
      end
      3: if (acc) begin
        if (d == m_csum) begin
          m_phase = 4; e_done = 1'b1; e_hold = 1'b0;
        end else model_fail(2);
      end
      default: if (r) begin
        m_phase = 0; e_done = 1'b0; e_error = 1'b0; e_code = 0; e_wl = 0; e_hold = 1'b1;
      end
    endcase
  endtask

  always @(posedge clk) begin
    #1;
    chk("in_ready", 32'(in_ready), 32'(m_phase < 4));
    chk("imem_we", 32'(imem_we), 32'(e_we));
    chk("imem_addr", 32'(imem_addr), e_addr);
    chk("imem_wdata", imem_wdata, e_wdata);
    chk("done", 32'(done), 32'(e_done));
    chk("error", 32'(error), 32'(e_error));
    chk("err_code", 32'(err_code), e_code);
    chk("core_hold", 32'(core_hold), 32'(e_hold));
    chk("words_loaded", 32'(words_loaded), e_wl);
    if (imem_we === 1'b1) mem[imem_addr] <= imem_wdata;
  end

  task automatic cyc(input logic v, input logic [7:0] d, input logic r);
    @(negedge clk);
    in_valid = v; in_data = d; restart = r;
    model_step(v, d, r);
  endtask

  task automatic send(input logic [7:0] b);
    cyc(1'b1, b, 1'b0);
  endtask

  task automatic send_gap(input logic [7:0] b, input int gap);
    repeat (gap) cyc(1'b0, 8'($urandom), 1'b0);
    cyc(1'b1, b, 1'b0);
  endtask

  task automatic settle();
    cyc(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #2;
  endtask

  task automatic do_restart();
    cyc(1'b0, 8'h00, 1'b1);
    settle();
  endtask

  task automatic send_frame(input logic [7:0] last);
    logic [7:0] f [10];
    f = '{8'hA5, 8'h02, 8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h13, 8'h00, 8'h00, 8'h00};
    for (int i = 0; i < 10; i++) send(f[i]);
    send(last);
  endtask

  task automatic async_reset();
    @(posedge clk);
    #3;
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_we", 32'(imem_we), 0);
    chk("rst_addr", 32'(imem_addr), 0);
    chk("rst_wdata", imem_wdata, 0);
    chk("rst_hold", 32'(core_hold), 1);
    chk("rst_done", 32'(done), 0);
    chk("rst_error", 32'(error), 0);
    chk("rst_code", 32'(err_code), 0);
    chk("rst_wl", 32'(words_loaded), 0);
    repeat (2) cyc(1'b0, 8'h00, 1'b0);
    @(negedge clk);
    reset = 1'b1; in_valid = 1'b0; restart = 1'b0;
    model_step(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic [7:0] b;
    logic [7:0] cs;
    int n;
    int rst_at;
    bit aborted;

    repeat (2) @(negedge clk);
    chk("init_hold", 32'(core_hold), 1);
    chk("init_done", 32'(done), 0);
    chk("init_wl", 32'(words_loaded), 0);
    chk("init_we", 32'(imem_we), 0);
    @(negedge clk);
    reset = 1'b1;
    model_step(1'b0, 8'h00, 1'b0);

    // Nominal two-word image
    send_frame(8'h33);
    settle();
    chk("nom_done", 32'(done), 1);
    chk("nom_hold", 32'(core_hold), 0);
    chk("nom_wl", 32'(words_loaded), 2);
    chk("nom_code", 32'(err_code), 0);
    chk("nom_mem0", mem[0], 32'hDEADBEEF);
    chk("nom_mem1", mem[1], 32'h00000013);

    do_restart();
    chk("rs_done", 32'(done), 0);
    chk("rs_hold", 32'(core_hold), 1);
    chk("rs_wl", 32'(words_loaded), 0);

    // Checksum mismatch; bytes presented in ERR must be ignored
    send_frame(8'h34);
    settle();
    chk("cs_error", 32'(error), 1);
    chk("cs_code", 32'(err_code), 2);
    chk("cs_hold", 32'(core_hold), 1);
    chk("cs_ready", 32'(in_ready), 0);
    chk("cs_wl", 32'(words_loaded), 2);
    send(8'hA5);
    send(8'h01);
    do_restart();

    // Bad counts
    send(8'hA5); send(8'h00);
    settle();
    chk("bc0_code", 32'(err_code), 1);
    chk("bc0_wl", 32'(words_loaded), 0);
    do_restart();
    send(8'hA5); send(8'h21);
    settle();
    chk("bc33_code", 32'(err_code), 1);
    do_restart();

    // Noise and gaps
    send(8'h00); send(8'hFF); send(8'h5A);
    send(8'hA5); send(8'h01); send(8'h78);
    send_gap(8'h56, 10); send_gap(8'h34, 10); send_gap(8'h12, 10);
    send(8'h09);
    settle();
    chk("nz_done", 32'(done), 1);
    chk("nz_mem0", mem[0], 32'h12345678);
    do_restart();

    // Timeout fires on exactly the TIMEOUT-th idle edge
    send(8'hA5); send(8'h01); send(8'hEF); send(8'hBE);
    repeat (TIMEOUT - 1) cyc(1'b0, 8'h00, 1'b0);
    @(posedge clk); #2;
    chk("to_early", 32'(error), 0);
    cyc(1'b0, 8'h00, 1'b0);
    @(posedge clk); #2;
    chk("to_error", 32'(error), 1);
    chk("to_code", 32'(err_code), 3);
    do_restart();

    // A byte on the expiring edge wins
    send(8'hA5); send(8'h01); send(8'hEF); send(8'hBE);
    repeat (TIMEOUT - 1) cyc(1'b0, 8'h00, 1'b0);
    send(8'hAD); send(8'hDE); send(8'h23);
    settle();
    chk("tow_error", 32'(error), 0);
    chk("tow_done", 32'(done), 1);
    chk("tow_mem0", mem[0], 32'hDEADBEEF);
    do_restart();

    // Asynchronous reset mid-DATA, then a clean reload
    send(8'hA5); send(8'h02); send(8'hEF); send(8'hBE); send(8'hAD);
    async_reset();
    send_frame(8'h33);
    settle();
    chk("rl_done", 32'(done), 1);
    chk("rl_wl", 32'(words_loaded), 2);
    do_restart();

    // Randomized frames
    for (int it = 0; it < 60; it++) begin
      if (m_phase >= 4) begin
        repeat ($urandom_range(0, 2)) cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'b0);
        cyc(1'b0, 8'h00, 1'b1);
      end
      repeat ($urandom_range(0, 3)) begin
        b = 8'($urandom);
        if (b == 8'hA5) b = 8'h00;
        send_gap(b, $urandom_range(0, 2));
      end
      send_gap(8'hA5, $urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) n = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(33, 255);
      else n = $urandom_range(1, 32);
      send_gap(8'(n), $urandom_range(0, 3));
      if (n == 0 || n > 32) continue;
      cs = 8'(n);
      rst_at = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 4 * n - 1) : -1;
      aborted = 1'b0;
      for (int i = 0; i < 4 * n; i++) begin
        if (i == rst_at) begin
          async_reset();
          aborted = 1'b1;
          break;
        end
        b = 8'($urandom);
        cs ^= b;
        send_gap(b, ($urandom_range(0, 9) == 0) ? $urandom_range(5, 30) : 0);
      end
      if (aborted) continue;
      if ($urandom_range(0, 14) == 0) repeat (TIMEOUT + 3) cyc(1'b0, 8'($urandom), 1'b0);
      else send_gap(($urandom_range(0, 4) == 0) ? (cs ^ 8'h01) : cs, $urandom_range(0, 3));
    end
    settle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
